// File: rtl/fifo_ctrl.sv
// FIFO controller for an external 8x8 single-port memory.
// Requests are accepted only in IDLE; a write takes one memory cycle, a read takes two.
module fifo_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       ready,
    output logic       push_ack,
    output logic [7:0] pop_data,
    output logic       pop_valid,
    output logic       full,
    output logic       empty,
    output logic [3:0] count,
    output logic       mem_rw,
    output logic [2:0] mem_addr,
    output logic [7:0] mem_i,
    input  logic [7:0] mem_o
);

    typedef enum logic [1:0] {IDLE, WR, RD_SETUP, RD_CAP} state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] wptr;
    logic [2:0] rptr;
    logic       push_accept;
    logic       pop_accept;

    assign ready    = (state == IDLE);
    assign push_ack = push_accept;
    assign full     = (count == 4'd8);
    assign empty    = (count == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pop has priority over push when both are requested and data is available.
    always_comb begin
        state_next  = state;
        push_accept = 1'b0;
        pop_accept  = 1'b0;
        case (state)
            IDLE: begin
                if (pop && !empty) begin
                    pop_accept = 1'b1;
                    state_next = RD_SETUP;
                end else if (push && !full) begin
                    push_accept = 1'b1;
                    state_next  = WR;
                end
            end
            WR:       state_next = IDLE;
            RD_SETUP: state_next = RD_CAP;
            RD_CAP:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= 3'd0;
            rptr      <= 3'd0;
            count     <= 4'd0;
            pop_data  <= 8'h00;
            pop_valid <= 1'b0;
            mem_rw    <= 1'b1;
            mem_addr  <= 3'd0;
            mem_i     <= 8'h00;
        end else begin
            pop_valid <= 1'b0;
            if (push_accept) begin
                mem_addr <= wptr;
                mem_i    <= push_data;
                mem_rw   <= 1'b0;
            end
            if (pop_accept) begin
                mem_addr <= rptr;
            end
            // Memory read data is combinational on mem_addr, so it is stable by RD_CAP.
            case (state)
                WR: begin
                    mem_rw <= 1'b1;
                    wptr   <= wptr + 3'd1;
                    count  <= count + 4'd1;
                end
                RD_CAP: begin
                    pop_data  <= mem_o;
                    pop_valid <= 1'b1;
                    rptr      <= rptr + 3'd1;
                    count     <= count - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter: none; depth fixed at 8 entries, width fixed at 8 bits, matching the 8x8 mem array.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 push  input  1  write request; sampled on rising clk.
REQ-005 push_data  input  8  data to enqueue; sampled with push.
REQ-006 pop  input  1  read request; sampled on rising clk.
REQ-007 ready  output  1  high only in IDLE; requests are ignored when low.
REQ-008 push_ack  output  1  one-cycle pulse, push accepted this cycle (combinational from inputs and state).
REQ-009 pop_data  output  8  registered dequeued byte.
REQ-010 pop_valid  output  1  one-cycle pulse, pop_data valid.
REQ-011 full  output  1  count == 8.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  4  occupancy, 0..8.
REQ-014 mem_rw  output  1  to mem RW; 0 = write, 1 = read.
REQ-015 mem_addr  output  3  to mem addr2..addr0.
REQ-016 mem_i  output  8  to mem i7..i0.
REQ-017 mem_o  input  8  from mem o7..o0; treated as combinational read of mem_addr when mem_rw = 1.

Function
REQ-018 FSM states IDLE, WR, RD_SETUP, RD_CAP; encoding free.
REQ-019 IDLE: pop & !empty -> RD_SETUP (pop accepted); else push & !full -> WR (push accepted, push_ack = 1); else stay.
REQ-020 Simultaneous push and pop in IDLE with !empty: pop wins, push not accepted, push_ack = 0; requester retries.
REQ-021 Simultaneous push and pop with empty: push accepted, pop ignored.
REQ-022 Push while full, pop while empty, or any request while !ready: ignored, no state or pointer change.
REQ-023 On push accept: mem_addr <= wptr, mem_i <= push_data, mem_rw <= 0 for exactly the WR cycle.
REQ-024 WR -> IDLE unconditionally; at that edge mem_rw <= 1, wptr <= wptr+1 mod 8, count <= count+1.
REQ-025 On pop accept: mem_addr <= rptr, mem_rw stays 1; RD_SETUP -> RD_CAP unconditionally.
REQ-026 RD_CAP -> IDLE; at that edge pop_data <= mem_o, pop_valid <= 1, rptr <= rptr+1 mod 8, count <= count-1.
REQ-027 pop_valid deasserts the following cycle; pop_data holds until the next capture.
REQ-028 Latency: push accepted cycle N -> write cycle N+1 -> ready, updated count at N+2; pop accepted cycle N -> pop_valid, updated count at N+3.
REQ-029 mem_rw = 0 only in WR; never low in any other state or during reset.
REQ-030 Pointers wrap 7 -> 0 with no other side effect; full/empty derive from count only, never pointer comparison.
REQ-031 mem_i and mem_addr hold their last values outside WR/RD states.

Reset
REQ-032 rst_n low asynchronously forces: state IDLE, wptr = rptr = 0, count = 0, empty = 1, full = 0, ready = 1, push_ack = 0, pop_valid = 0, pop_data = 0x00, mem_rw = 1, mem_addr = 0, mem_i = 0x00.
REQ-033 Reset asserted mid-WR aborts the write immediately (mem_rw rises with rst_n fall); count not incremented.
REQ-034 Reset asserted mid-read: no pop_valid pulse is produced; the mem array contents are not cleared by this block.
REQ-035 First accepted request is sampled no earlier than the first rising clk after rst_n deasserts.

Verification
REQ-036 Reset, then push 12,13,...,19 one at a time -> mem writes at addr 0..7, full = 1 and count = 8 after the eighth.
REQ-037 Ninth push 0xAA while full -> push_ack = 0, no mem_rw low pulse, count stays 8.
REQ-038 Eight pops -> pop_data 12..19 in order, each pop_valid exactly 3 cycles after acceptance, empty = 1 at end.
REQ-039 Wrap: push 8, pop 3, push 3 (0xA0..0xA2) -> writes at addr 0,1,2, pop order 15..19 then 0xA0..0xA2.
REQ-040 Push and pop asserted together with count = 2 -> pop served, push_ack = 0; with count = 0 -> push served, pop ignored.
REQ-041 rst_n pulled low during WR cycle -> mem_rw = 1 within the same time step, count = 0, ready = 1.
